chip8_display_scanout: RTL and testbench

// - Reader side of the CHIP-8 framebuffer: display_in[2047:0] holds the 64x32 frame; pixel (x,y) is bit 2047-(y*64+x).
// - On start, snapshots the frame and streams it row-major as 1-bit pixels over a valid/ready stream to the video/host sink.
// - Optional integer upscaling: each pixel is repeated SCALE times per line and each line SCALE times.
// - The snapshot gives tear-free output while the draw unit keeps updating the framebuffer.

---
 rtl/chip8_pkg.sv | 20 ++
 rtl/chip8_scan_counter.sv | 82 ++++++++
 rtl/chip8_display_scanout.sv | 101 ++++++++++
 tb/tb_chip8_display_scanout.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/chip8_pkg.sv
// Shared CHIP-8 display definitions used by the scan-out block and the draw unit.
// Provides frame geometry, the pixel-to-bit mapping and the scan-out state encoding.
package chip8_pkg;

   localparam int CHIP8_W       = 64;
   localparam int CHIP8_H       = 32;
   localparam int CHIP8_FB_BITS = 2048;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STREAM = 2'd1,
      ST_DONE   = 2'd2
   } scan_state_e;

   // Pixel (x,y) lives at bit 2047-(y*64+x); {y,x} is exactly y*64+x.
   function automatic logic [10:0] fb_index(input logic [5:0] x, input logic [4:0] y);
      return 11'(CHIP8_FB_BITS - 1) - {y, x};
   endfunction

endpackage

// File: rtl/chip8_scan_counter.sv
// Cascaded scan position counter: sx (pixel repeat) -> x -> sy (line repeat) -> y.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   clear         zero all counters (frame start)
//   advance       step one output beat
//   x, y          source pixel coordinates of the current beat
//   sof, eol      first beat of frame / last beat of an output line
//   last          final beat of the frame
module chip8_scan_counter
   import chip8_pkg::*;
#(
   parameter int SCALE = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       clear,
   input  logic       advance,
   output logic [5:0] x,
   output logic [4:0] y,
   output logic       sof,
   output logic       eol,
   output logic       last
);

   localparam int SW = (SCALE > 1) ? $clog2(SCALE) : 1;
   localparam logic [SW-1:0] S_MAX = SW'(SCALE - 1);

   logic [SW-1:0] sx_q, sx_d, sy_q, sy_d;
   logic [5:0]    x_q, x_d;
   logic [4:0]    y_q, y_d;
   logic          sx_wrap, x_wrap, sy_wrap, y_wrap;

   assign sx_wrap = (sx_q == S_MAX);
   assign x_wrap  = (x_q == 6'(CHIP8_W - 1));
   assign sy_wrap = (sy_q == S_MAX);
   assign y_wrap  = (y_q == 5'(CHIP8_H - 1));

   always_comb begin
      sx_d = sx_q;
      x_d  = x_q;
      sy_d = sy_q;
      y_d  = y_q;
      if (clear) begin
         sx_d = '0;
         x_d  = '0;
         sy_d = '0;
         y_d  = '0;
      end else if (advance) begin
         sx_d = sx_wrap ? '0 : sx_q + 1'b1;
         if (sx_wrap) begin
            x_d = x_wrap ? '0 : x_q + 1'b1;
            if (x_wrap) begin
               sy_d = sy_wrap ? '0 : sy_q + 1'b1;
               if (sy_wrap) begin
                  y_d = y_wrap ? '0 : y_q + 1'b1;
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sx_q <= '0;
         x_q  <= '0;
         sy_q <= '0;
         y_q  <= '0;
      end else begin
         sx_q <= sx_d;
         x_q  <= x_d;
         sy_q <= sy_d;
         y_q  <= y_d;
      end
   end

   assign x    = x_q;
   assign y    = y_q;
   assign sof  = (sx_q == '0) && (x_q == '0) && (sy_q == '0) && (y_q == '0);
   assign eol  = x_wrap && sx_wrap;
   assign last = x_wrap && y_wrap && sx_wrap && sy_wrap;

endmodule

// File: rtl/chip8_display_scanout.sv
// CHIP-8 framebuffer scan-out: snapshots the 64x32 frame on start and streams it
// row-major as 1-bit pixels over valid/ready, each pixel and line repeated SCALE times.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   start            request one frame (ignored unless idle)
//   display_in       live framebuffer, captured on an accepted start
//   pix_valid/ready  stream handshake
//   pix_data         pixel value (1 = lit)
//   pix_sof/pix_eol  frame start / line end markers
//   busy             frame in progress
//   frame_done       one-cycle pulse after the last beat transfers
//
// state     | meaning
// ST_IDLE   | waiting for start
// ST_STREAM | presenting beats, counters step on each transfer
// ST_DONE   | frame_done pulse, start ignored
module chip8_display_scanout
   import chip8_pkg::*;
#(
   parameter int SCALE = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [CHIP8_FB_BITS-1:0] display_in,
   output logic                     pix_valid,
   input  logic                     pix_ready,
   output logic                     pix_data,
   output logic                     pix_sof,
   output logic                     pix_eol,
   output logic                     busy,
   output logic                     frame_done
);

   scan_state_e              state_q, state_d;
   logic [CHIP8_FB_BITS-1:0] snap_q;
   logic                     capture, cnt_adv, streaming;
   logic [5:0]               cx;
   logic [4:0]               cy;
   logic                     c_sof, c_eol, c_last;

   chip8_scan_counter #(.SCALE(SCALE)) u_cnt (
      .clk     (clk),
      .rst     (rst),
      .clear   (capture),
      .advance (cnt_adv),
      .x       (cx),
      .y       (cy),
      .sof     (c_sof),
      .eol     (c_eol),
      .last    (c_last)
   );

   always_comb begin
      state_d = state_q;
      capture = 1'b0;
      cnt_adv = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               capture = 1'b1;
               state_d = ST_STREAM;
            end
         end
         ST_STREAM: begin
            cnt_adv = pix_ready;
            if (pix_ready && c_last) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         snap_q  <= '0;
      end else begin
         state_q <= state_d;
         if (capture) begin
            snap_q <= display_in;
         end
      end
   end

   // Markers and data are gated so they read 0 outside a frame.
   assign streaming  = (state_q == ST_STREAM);
   assign pix_valid  = streaming;
   assign busy       = streaming;
   assign frame_done = (state_q == ST_DONE);
   assign pix_data   = streaming & snap_q[fb_index(cx, cy)];
   assign pix_sof    = streaming & c_sof;
   assign pix_eol    = streaming & c_eol;

endmodule

// File: tb/tb_chip8_display_scanout.sv
module tb_chip8_display_scanout;

   logic          clk = 1'b0;
   logic          rst, start1, start2, ready;
   logic [2047:0] disp;
   logic [2047:0] exp_fb;
   logic          v1, d1, sof1, eol1, busy1, done1;
   logic          v2, d2, sof2, eol2, busy2, done2;
   logic          sel;
   logic          v, d, sof, eol, busy, done;
   int            n_cmp = 0;
   int            n_bad = 0;
   int            ones_cnt;
   int            first_one;

   always #5 clk = ~clk;

   chip8_display_scanout #(.SCALE(1)) u_s1 (
      .clk(clk), .rst(rst), .start(start1), .display_in(disp),
      .pix_valid(v1), .pix_ready(ready), .pix_data(d1), .pix_sof(sof1),
      .pix_eol(eol1), .busy(busy1), .frame_done(done1)
   );

   chip8_display_scanout #(.SCALE(2)) u_s2 (
      .clk(clk), .rst(rst), .start(start2), .display_in(disp),
      .pix_valid(v2), .pix_ready(ready), .pix_data(d2), .pix_sof(sof2),
      .pix_eol(eol2), .busy(busy2), .frame_done(done2)
   );

   assign v    = sel ? v2    : v1;
   assign d    = sel ? d2    : d1;
   assign sof  = sel ? sof2  : sof1;
   assign eol  = sel ? eol2  : eol1;
   assign busy = sel ? busy2 : busy1;
   assign done = sel ? done2 : done1;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Expected pixel for output beat b at scale sc, from the bench's own frame copy.
   function automatic logic exp_pix(input int sc, input int b);
      int line, ox, px, py;
      line = b / (64 * sc);
      ox   = b % (64 * sc);
      px   = ox / sc;
      py   = line / sc;
      return exp_fb[2047 - (py * 64 + px)];
   endfunction

   task automatic start_frame(input int sc);
      sel = (sc == 2);
      if (sc == 2) start2 = 1'b1; else start1 = 1'b1;
      step();
      start1 = 1'b0;
      start2 = 1'b0;
   endtask

   // mode 0: ready always high; mode 1: ready toggles 1,0,1,0...
   task automatic stream(input int sc, input int mode, input int nbeats,
                         input int mutate_at, input int start_at);
      int   beat;
      int   cyc;
      logic rdy;
      beat = 0;
      cyc = 0;
      ones_cnt = 0;
      first_one = -1;
      while (beat < nbeats && cyc < nbeats * 3 + 16) begin
         rdy   = (mode == 0) ? 1'b1 : ((cyc % 2) == 0);
         ready = rdy;
         if (sc == 2) start2 = (beat == start_at); else start1 = (beat == start_at);
         check("valid", v, 1);
         check("busy", busy, 1);
         check("data", d, exp_pix(sc, beat));
         check("sof", sof, beat == 0);
         check("eol", eol, (beat % (64 * sc)) == 64 * sc - 1);
         if (rdy && d) begin
            ones_cnt++;
            if (first_one < 0) first_one = beat;
         end
         if (rdy && beat == mutate_at) disp = '0;
         step();
         if (rdy) beat++;
         cyc++;
      end
      start1 = 1'b0;
      start2 = 1'b0;
      check("transfers", beat, nbeats);
      if (mode == 0) check("cycles", cyc, nbeats);
   endtask

   task automatic finish_frame(input logic start_in_done);
      check("done_pulse", done, 1);
      check("done_busy", busy, 0);
      check("done_valid", v, 0);
      if (start_in_done) start1 = 1'b1;
      step();
      start1 = 1'b0;
      check("done_end", done, 0);
      check("idle_valid", v, 0);
      check("idle_busy", busy, 0);
   endtask

   initial begin
      rst    = 1'b1;
      start1 = 1'b0;
      start2 = 1'b0;
      ready  = 1'b0;
      disp   = '0;
      exp_fb = '0;
      sel    = 1'b0;
      step();
      step();
      for (int s = 0; s < 2; s++) begin
         sel = (s == 1);
         #0;
         check("rst_valid", v, 0);
         check("rst_data", d, 0);
         check("rst_sof", sof, 0);
         check("rst_eol", eol, 0);
         check("rst_busy", busy, 0);
         check("rst_done", done, 0);
      end
      rst = 1'b0;
      sel = 1'b0;
      step();

      // T1: single lit pixel (0,0)
      exp_fb = '0;
      exp_fb[2047] = 1'b1;
      disp = exp_fb;
      start_frame(1);
      stream(1, 0, 2048, -1, -1);
      check("t1_ones", ones_cnt, 1);
      check("t1_first", first_one, 0);
      finish_frame(1'b0);

      // T2: checkerboard under alternating backpressure
      for (int y = 0; y < 32; y++)
         for (int x = 0; x < 64; x++)
            exp_fb[2047 - (y * 64 + x)] = (x ^ y) & 1;
      disp = exp_fb;
      start_frame(1);
      stream(1, 1, 2048, -1, -1);
      check("t2_ones", ones_cnt, 1024);
      finish_frame(1'b0);

      // T3: snapshot isolation, then a fresh capture of the cleared frame
      exp_fb = '1;
      disp = exp_fb;
      start_frame(1);
      stream(1, 0, 2048, 500, -1);
      check("t3_ones", ones_cnt, 2048);
      finish_frame(1'b0);
      exp_fb = '0;
      start_frame(1);
      stream(1, 0, 2048, -1, -1);
      check("t3b_ones", ones_cnt, 0);
      finish_frame(1'b0);

      // T4: SCALE=2, only pixel (63,31)
      exp_fb = '0;
      exp_fb[0] = 1'b1;
      disp = exp_fb;
      start_frame(2);
      stream(2, 0, 8192, -1, -1);
      check("t4_ones", ones_cnt, 4);
      check("t4_first", first_one, 8062);
      finish_frame(1'b0);
      sel = 1'b0;

      // T5: reset on the cycle of beat 100
      for (int y = 0; y < 32; y++)
         for (int x = 0; x < 64; x++)
            exp_fb[2047 - (y * 64 + x)] = (x ^ y) & 1;
      disp = exp_fb;
      start_frame(1);
      stream(1, 0, 100, -1, -1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("t5_valid", v, 0);
      check("t5_busy", busy, 0);
      check("t5_done", done, 0);
      step();
      check("t5_done2", done, 0);
      check("t5_valid2", v, 0);
      start_frame(1);
      check("t5_sof", sof, 1);
      stream(1, 0, 2048, -1, -1);
      finish_frame(1'b0);

      // T6: start while busy and during DONE ignored; start with rst loses
      start_frame(1);
      stream(1, 0, 2048, -1, 10);
      finish_frame(1'b1);
      step();
      check("t6_one_frame", v, 0);
      rst = 1'b1;
      start1 = 1'b1;
      step();
      rst = 1'b0;
      start1 = 1'b0;
      check("t6_rst_busy", busy, 0);
      check("t6_rst_valid", v, 0);
      step();
      check("t6_rst_busy2", busy, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
